traffic_light: RTL and testbench

TRAFFIC_LIGHT -- requirements
Module: traffic_light

---
 rtl/traffic_light.sv | 92 +++++++++
 tb/tb_traffic_light.sv | 134 +++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// Three-phase traffic light controller: RED -> GREEN -> YELLOW -> RED.
// Each phase lasts its parameter in enabled cycles; enable=0 freezes everything.
module traffic_light #(
    parameter int unsigned RED_CYCLES    = 30,
    parameter int unsigned GREEN_CYCLES  = 20,
    parameter int unsigned YELLOW_CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam int unsigned MaxRg     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int unsigned MaxCycles = (MaxRg > YELLOW_CYCLES) ? MaxRg : YELLOW_CYCLES;
    // A one-cycle-only build would give a zero-width counter; keep at least one bit.
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] RedLast    = CntW'(RED_CYCLES - 1);
    localparam logic [CntW-1:0] GreenLast  = CntW'(GREEN_CYCLES - 1);
    localparam logic [CntW-1:0] YellowLast = CntW'(YELLOW_CYCLES - 1);

    typedef enum logic [1:0] {
        StRed    = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2
    } state_e;

    state_e          state_q, state_d, state_nxt;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_last;
    logic [2:0]      lamp_q, lamp_d;
    logic            illegal;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        state_nxt = StRed;
        cnt_last  = '0;
        illegal   = 1'b0;

        case (state_q)
            StRed: begin
                cnt_last  = RedLast;
                state_nxt = StGreen;
            end
            StGreen: begin
                cnt_last  = GreenLast;
                state_nxt = StYellow;
            end
            StYellow: begin
                cnt_last  = YellowLast;
                state_nxt = StRed;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal encodings recover to RED even while paused.
        if (illegal) begin
            state_d = StRed;
            cnt_d   = '0;
        end else if (enable) begin
            if (cnt_q == cnt_last) begin
                state_d = state_nxt;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        // Lamps are registered from the next state, so they track state_q exactly.
        lamp_d = {state_d == StRed, state_d == StYellow, state_d == StGreen};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRed;
            cnt_q   <= '0;
            lamp_q  <= 3'b100;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lamp_q  <= lamp_d;
        end
    end

    assign red    = lamp_q[2];
    assign yellow = lamp_q[1];
    assign green  = lamp_q[0];

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: default timing, pause, mid-phase reset,
// long disabled hold, and an all-ones build stepping R,G,Y every cycle.
module tb_traffic_light;

    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic red, yellow, green;
    logic reset_f = 1'b0;
    logic enable_f = 1'b0;
    logic red_f, yellow_f, green_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .red    (red),
        .yellow (yellow),
        .green  (green)
    );

    traffic_light #(
        .RED_CYCLES    (1),
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1)
    ) dut_fast (
        .clk    (clk),
        .reset  (reset_f),
        .enable (enable_f),
        .red    (red_f),
        .yellow (yellow_f),
        .green  (green_f)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample both DUTs and confirm one-hot lamps.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot", {2'b00, ($countones({red, yellow, green}) == 1)}, 3'b001);
        check("onehot_fast", {2'b00, ($countones({red_f, yellow_f, green_f}) == 1)}, 3'b001);
    endtask

    task automatic run(input string tag, input int n, input logic [2:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, {red, yellow, green}, exp);
        end
    endtask

    initial begin
        // Reset for two cycles with enable high: reset wins.
        reset  = 1'b0;
        enable = 1'b1;
        run("reset_state", 2, LampR);

        // Full default cycle: 30 red, 20 green, 5 yellow, then red.
        reset = 1'b1;
        run("red_30", 29, LampR);
        run("green_20", 20, LampG);
        run("yellow_5", 5, LampY);
        run("red_again", 1, LampR);

        // Pause after 10 green cycles have elapsed.
        run("red_before_pause", 29, LampR);
        run("green_entry", 1, LampG);
        run("green_pre_pause", 10, LampG);
        enable = 1'b0;
        run("green_paused", 10, LampG);
        enable = 1'b1;
        run("green_resumed", 9, LampG);
        run("yellow_after_pause", 1, LampY);

        // Reset mid-YELLOW gives red and a fresh 30-cycle RED.
        run("yellow_mid", 2, LampY);
        reset = 1'b0;
        run("reset_in_yellow", 1, LampR);
        reset = 1'b1;
        run("red_fresh", 29, LampR);
        run("green_after_fresh", 1, LampG);

        // Disabled from reset release: red holds for 50 cycles, counter still at 0.
        reset = 1'b0;
        run("reset_again", 1, LampR);
        reset  = 1'b1;
        enable = 1'b0;
        run("red_disabled", 50, LampR);
        enable = 1'b1;
        run("red_after_enable", 29, LampR);
        run("green_after_enable", 1, LampG);

        // All-ones build changes lamp every enabled cycle.
        reset_f = 1'b0;
        tick();
        check("fast_reset", {red_f, yellow_f, green_f}, LampR);
        reset_f  = 1'b1;
        enable_f = 1'b1;
        tick();
        check("fast_g1", {red_f, yellow_f, green_f}, LampG);
        tick();
        check("fast_y1", {red_f, yellow_f, green_f}, LampY);
        tick();
        check("fast_r1", {red_f, yellow_f, green_f}, LampR);
        tick();
        check("fast_g2", {red_f, yellow_f, green_f}, LampG);
        enable_f = 1'b0;
        tick();
        check("fast_hold", {red_f, yellow_f, green_f}, LampG);
        enable_f = 1'b1;
        tick();
        check("fast_y2", {red_f, yellow_f, green_f}, LampY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
